// File: rtl/bowling_pkg.sv
// Shared constants and types for the bowling frame sequencer.
// The optional running score total is enabled by defining SCORE_TOTAL_EN.
package bowling_pkg;

    // Frames per game; the last frame owns the fill balls.
    localparam int FRAMES   = 10;
    // Pins per rack; limit for a single roll and for a two-roll frame sum.
    localparam int MAX_PINS = 10;
    // Width of one weighted add command (must hold 3 x MAX_PINS).
    localparam int ADD_W    = 5;
    // Width of the optional running total (0..300).
    localparam int TOTAL_W  = 9;

    // Sequencer states: two regular rolls, two fill rolls, game over.
    typedef enum logic [2:0] {
        ROLL1 = 3'd0,
        ROLL2 = 3'd1,
        FILL1 = 3'd2,
        FILL2 = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bowling_bonus_tracker.sv
// Pending strike/spare bonus tracker.
// b0 is the bonus count applied to the roll being taken now, b1 the count
// already owed to the roll after it. Both shift forward on each accepted roll.
module bowling_bonus_tracker
    import bowling_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       accept_i,     // roll accepted this cycle
    input  logic       new_next_i,   // this roll owes a bonus to the next roll
    input  logic       new_after_i,  // this roll owes a bonus to the roll after next
    input  logic       base_i,       // 1 for regular rolls, 0 for fill rolls
    output logic [1:0] mult_o        // weight of the current roll, 0..3
);

    logic [1:0] b0_q, b0_d;
    logic       b1_q, b1_d;

    // Shift the bonus pipeline forward by one roll on every accepted roll.
    always_comb begin
        b0_d = b0_q;
        b1_d = b1_q;
        if (accept_i) begin
            b0_d = {1'b0, b1_q} + {1'b0, new_next_i};
            b1_d = new_after_i;
        end
    end

    // Bonus registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0_q <= 2'd0;
            b1_q <= 1'b0;
        end else begin
            b0_q <= b0_d;
            b1_q <= b1_d;
        end
    end

    // b0 never exceeds 2, so base + b0 fits in two bits.
    assign mult_o = {1'b0, base_i} + b0_q;

endmodule

// File: rtl/bowling_frame_ctrl.sv
// Bowling frame/roll sequencer: one weighted add command per accepted roll.
// Optional feature macro: SCORE_TOTAL_EN adds a registered running total port.
//
// Handshake: upd is a strobe with no back-pressure; every cycle with upd=1
// is one roll. The result (add_en/add_val or err) appears one cycle later.
module bowling_frame_ctrl
    import bowling_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               upd,
    input  logic [3:0]         pins,
    output logic               add_en,
    output logic [ADD_W-1:0]   add_val,
    output logic [3:0]         frame,
    output logic [1:0]         roll,
    output logic               done,
    output state_t             dbg_state,
    output logic               err
`ifdef SCORE_TOTAL_EN
    ,
    output logic [TOTAL_W-1:0] total
`endif
);

    localparam logic [3:0] PINS_MAX   = 4'(MAX_PINS);
    localparam logic [4:0] SUM_MAX    = 5'(MAX_PINS);
    localparam logic [3:0] FRAME_LAST = 4'(FRAMES);

    state_t     state_q, state_d;
    logic [3:0] frame_q, frame_d;
    logic [1:0] roll_q, roll_d;
    logic [3:0] first_q, first_d;
    logic       fill_strike_q, fill_strike_d;  // last frame opened with a strike

    logic             add_en_q, add_en_d;
    logic [ADD_W-1:0] add_val_q, add_val_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [4:0] pins_sum;
    logic       illegal, accept, reject;
    logic       is_strike, is_spare, last_frame;
    logic       base, new_next, new_after;
    logic [1:0] mult;

    // Classify the incoming roll: legality, strike/spare, last frame.
    always_comb begin
        pins_sum = {1'b0, first_q} + {1'b0, pins};
        illegal  = (pins > PINS_MAX);
        case (state_q)
            ROLL2:   if (pins_sum > SUM_MAX) illegal = 1'b1;
            // Second fill ball after a non-strike first fill shares the rack.
            FILL2:   if ((first_q != PINS_MAX) && (pins_sum > SUM_MAX)) illegal = 1'b1;
            default: ;
        endcase
        accept     = upd && (state_q != DONE) && !illegal;
        reject     = upd && (state_q != DONE) && illegal;
        is_strike  = (state_q == ROLL1) && (pins == PINS_MAX);
        is_spare   = (state_q == ROLL2) && (pins_sum == SUM_MAX);
        last_frame = (frame_q == FRAME_LAST);
    end

    // Next-state logic: frame/roll bookkeeping on accepted rolls only.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        roll_d        = roll_q;
        first_d       = first_q;
        fill_strike_d = fill_strike_q;
        if (accept) begin
            case (state_q)
                ROLL1: begin
                    if (is_strike) begin
                        if (last_frame) begin
                            state_d       = FILL1;
                            roll_d        = 2'd1;
                            fill_strike_d = 1'b1;
                        end else begin
                            frame_d = frame_q + 4'd1;
                            roll_d  = 2'd0;
                        end
                    end else begin
                        first_d = pins;
                        state_d = ROLL2;
                        roll_d  = 2'd1;
                    end
                end
                ROLL2: begin
                    if (last_frame) begin
                        if (is_spare) begin
                            state_d       = FILL1;
                            roll_d        = 2'd2;
                            fill_strike_d = 1'b0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = ROLL1;
                        frame_d = frame_q + 4'd1;
                        roll_d  = 2'd0;
                    end
                end
                FILL1: begin
                    // A strike earns two fill balls, a spare only one.
                    if (fill_strike_q) begin
                        first_d = pins;
                        state_d = FILL2;
                        roll_d  = 2'd2;
                    end else begin
                        state_d = DONE;
                    end
                end
                FILL2:   state_d = DONE;
                default: ;
            endcase
        end
    end

    // Output logic: bonus creation, weighted add command, error pulse.
    always_comb begin
        base      = (state_q == ROLL1) || (state_q == ROLL2);
        new_next  = accept && (is_strike || is_spare);
        new_after = accept && is_strike;
        add_en_d  = accept;
        add_val_d = accept ? (ADD_W'(pins) * ADD_W'(mult)) : '0;
        err_d     = reject;
        done_d    = (state_d == DONE);
    end

    // State and frame bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ROLL1;
            frame_q       <= 4'd1;
            roll_q        <= 2'd0;
            first_q       <= 4'd0;
            fill_strike_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            roll_q        <= roll_d;
            first_q       <= first_d;
            fill_strike_q <= fill_strike_d;
        end
    end

    // Registered outputs, one cycle after the roll strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_en_q  <= 1'b0;
            add_val_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            add_en_q  <= add_en_d;
            add_val_q <= add_val_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    bowling_bonus_tracker u_bonus (
        .clk         (clk),
        .rst         (rst),
        .accept_i    (accept),
        .new_next_i  (new_next),
        .new_after_i (new_after),
        .base_i      (base),
        .mult_o      (mult)
    );

`ifdef SCORE_TOTAL_EN
    logic [TOTAL_W-1:0] total_q;

    // Running score, moving in step with the add command it mirrors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
        end else if (add_en_d) begin
            total_q <= total_q + TOTAL_W'(add_val_d);
        end
    end

    assign total = total_q;
`endif

    assign add_en    = add_en_q;
    assign add_val   = add_val_q;
    assign err       = err_q;
    assign done      = done_q;
    assign frame     = frame_q;
    assign roll      = roll_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bowling_frame_ctrl.sv
// Directed self-checking bench for bowling_frame_ctrl.
// Define SCORE_TOTAL_EN for both RTL and bench to also check the total port.
module tb_bowling_frame_ctrl;
    import bowling_pkg::*;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst;
    logic               upd;
    logic [3:0]         pins;
    logic               add_en;
    logic [ADD_W-1:0]   add_val;
    logic [3:0]         frame;
    logic [1:0]         roll;
    logic               done;
    state_t             dbg_state;
    logic               err;
`ifdef SCORE_TOTAL_EN
    logic [TOTAL_W-1:0] total;
`endif

    always #5 clk = ~clk;

    bowling_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .upd       (upd),
        .pins      (pins),
        .add_en    (add_en),
        .add_val   (add_val),
        .frame     (frame),
        .roll      (roll),
        .done      (done),
        .dbg_state (dbg_state),
        .err       (err)
`ifdef SCORE_TOTAL_EN
        ,
        .total     (total)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks  = 0;
    int n_errors  = 0;
    int exp_total = 0;
    logic [3:0]       pins_q[$];
    logic [ADD_W-1:0] exp_q[$];

    int mixed_pins[16] = '{8, 2, 10, 7, 1, 10, 10, 10, 0, 10, 3, 7, 5, 5, 8, 1};
    int mixed_exp[16]  = '{8, 2, 20, 14, 2, 10, 20, 30, 0, 20, 6, 7, 10, 5, 16, 1};
    int perfect_exp[12] = '{10, 20, 30, 30, 30, 30, 30, 30, 30, 30, 20, 10};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_total(input string tag);
`ifdef SCORE_TOTAL_EN
        check(tag, int'(total), exp_total);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst  = 1'b1;
        upd  = 1'b0;
        pins = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_total = 0;
        pins_q.delete();
        exp_q.delete();
    endtask

    // One roll strobe; returns on the negedge where its result is visible.
    task automatic do_roll(input logic [3:0] p);
        @(negedge clk);
        upd  = 1'b1;
        pins = p;
        @(negedge clk);
        upd  = 1'b0;
    endtask

    task automatic push(input int p, input int e);
        pins_q.push_back(4'(p));
        exp_q.push_back(ADD_W'(e));
    endtask

    // Plays every queued roll, comparing each add command against exp_q.
    task automatic run_game(input string tag, input bool_last_done);
        int n;
        logic [3:0] p;
        logic [ADD_W-1:0] e;
        n = 0;
        while (pins_q.size() > 0) begin
            p = pins_q.pop_front();
            e = exp_q.pop_front();
            do_roll(p);
            n++;
            check($sformatf("%s r%0d add_en", tag, n), int'(add_en), 1);
            check($sformatf("%s r%0d add_val", tag, n), int'(add_val), int'(e));
            check($sformatf("%s r%0d done", tag, n), int'(done),
                  int'(bool_last_done && (pins_q.size() == 0)));
            exp_total += int'(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state.
        do_reset();
        check("rst add_en", int'(add_en), 0);
        check("rst add_val", int'(add_val), 0);
        check("rst frame", int'(frame), 1);
        check("rst roll", int'(roll), 0);
        check("rst done", int'(done), 0);
        check("rst err", int'(err), 0);
        check("rst state", int'(dbg_state), int'(ROLL1));
        check_total("rst total");

        // 1. Perfect game with upd held high for twelve consecutive cycles.
        @(negedge clk);
        upd  = 1'b1;
        pins = 4'd10;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 11) upd = 1'b0;
            check($sformatf("perfect r%0d add_en", i + 1), int'(add_en), 1);
            check($sformatf("perfect r%0d add_val", i + 1), int'(add_val), perfect_exp[i]);
            check($sformatf("perfect r%0d done", i + 1), int'(done), int'(i == 11));
            exp_total += perfect_exp[i];
            if (i == 8)  check("perfect frame10", int'(frame), 10);
            if (i == 9)  check("perfect fill1 roll", int'(roll), 1);
            if (i == 10) check("perfect fill2 roll", int'(roll), 2);
        end
        check_total("perfect total");
        @(negedge clk);
        check("perfect idle add_en", int'(add_en), 0);
        check("perfect done level", int'(done), 1);
        check("perfect state", int'(dbg_state), int'(DONE));

        // 2. Mixed game, no fill balls.
        do_reset();
        for (int i = 0; i < 16; i++) push(mixed_pins[i], mixed_exp[i]);
        run_game("mixed", 1'b1);
        check("mixed frame", int'(frame), 10);
        check_total("mixed total");

        // 3. Nine strikes then an open last frame.
        do_reset();
        push(10, 10);
        push(10, 20);
        for (int i = 0; i < 7; i++) push(10, 30);
        push(8, 24);
        check("nine strikes pre-run done", int'(done), 0);
        run_game("nine", 1'b0);
        check("nine frame10", int'(frame), 10);
        push(1, 2);
        run_game("nine last", 1'b1);
        check_total("nine total");

        // 4. Illegal rolls are rejected without disturbing state.
        do_reset();
        do_roll(4'd11);
        check("ill11 err", int'(err), 1);
        check("ill11 add_en", int'(add_en), 0);
        check("ill11 frame", int'(frame), 1);
        check("ill11 roll", int'(roll), 0);
        @(negedge clk);
        check("ill11 err pulse", int'(err), 0);
        do_roll(4'd6);
        check("ill 6 add_en", int'(add_en), 1);
        check("ill 6 add_val", int'(add_val), 6);
        check("ill 6 roll", int'(roll), 1);
        do_roll(4'd5);
        check("ill 6+5 err", int'(err), 1);
        check("ill 6+5 add_en", int'(add_en), 0);
        check("ill 6+5 roll", int'(roll), 1);
        do_roll(4'd4);
        check("ill spare add_en", int'(add_en), 1);
        check("ill spare add_val", int'(add_val), 4);
        check("ill spare err", int'(err), 0);
        check("ill spare frame", int'(frame), 2);
        do_roll(4'd10);
        check("ill after spare add_val", int'(add_val), 20);

        // 5. Last-frame spare with one fill ball, then ignored strobes.
        do_reset();
        for (int i = 0; i < 18; i++) push(0, 0);
        push(9, 9);
        push(1, 1);
        run_game("spare10", 1'b0);
        check("spare10 state", int'(dbg_state), int'(FILL1));
        check("spare10 roll", int'(roll), 2);
        push(10, 10);
        run_game("spare10 fill", 1'b1);
        check_total("spare10 total");
        do_roll(4'd10);
        check("done ignore add_en", int'(add_en), 0);
        check("done ignore err", int'(err), 0);
        do_roll(4'd15);
        check("done ignore bad err", int'(err), 0);
        check("done still set", int'(done), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        // 6. Reset mid-frame 5 with pending strike bonuses.
        do_reset();
        push(10, 10);
        push(10, 20);
        push(10, 30);
        push(10, 30);
        push(5, 15);
        run_game("abort", 1'b0);
        check("abort frame5", int'(frame), 5);
        #2;
        rst = 1'b1;
        #1;
        check("async rst add_en", int'(add_en), 0);
        check("async rst add_val", int'(add_val), 0);
        check("async rst frame", int'(frame), 1);
        check("async rst roll", int'(roll), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_total = 0;
        check_total("async rst total");
        do_roll(4'd3);
        check("post rst add_en", int'(add_en), 1);
        check("post rst add_val", int'(add_val), 3);
        check("post rst frame", int'(frame), 1);
        check("post rst roll", int'(roll), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
